control_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the combinational decode control unit.

---
 rtl/control_unit_pipe_if.sv | 49 ++++
 rtl/control_unit_pipe.sv | 178 +++++++++++++++++
 tb/tb_control_unit_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pipe_if.sv
// Bundles the ID-stage request, pipeline control inputs and registered
// ID/EX control outputs of control_unit_pipe into one port.
interface control_unit_pipe_if #(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int ALU_OP_W = 2,
   parameter int CNT_W    = 16
);
   // ID-stage request and pipeline control
   logic                id_valid;
   logic [OPCODE_W-1:0] opcode;
   logic [REG_W-1:0]    id_rs;
   logic [REG_W-1:0]    id_rt;
   logic                stall_in;
   logic                flush;

   // EX-stage control register and status
   logic                ex_valid;
   logic                reg_dst;
   logic                branch;
   logic                branch_ne;
   logic                jump;
   logic                mem_read;
   logic                mem_to_reg;
   logic                mem_write;
   logic                alu_src;
   logic                reg_write;
   logic [ALU_OP_W-1:0] alu_op;
   logic [REG_W-1:0]    ex_rt;
   logic                illegal_op;
   logic                stall_out;
   logic [CNT_W-1:0]    bubble_cnt;

   // Decode-stage side: drives the request, observes the EX controls
   modport master (
      output id_valid, opcode, id_rs, id_rt, stall_in, flush,
      input  ex_valid, reg_dst, branch, branch_ne, jump, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, alu_op, ex_rt, illegal_op,
             stall_out, bubble_cnt
   );

   // Control unit side
   modport slave (
      input  id_valid, opcode, id_rs, id_rt, stall_in, flush,
      output ex_valid, reg_dst, branch, branch_ne, jump, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, alu_op, ex_rt, illegal_op,
             stall_out, bubble_cnt
   );
endinterface

// File: rtl/control_unit_pipe.sv
// Registered ID/EX control unit: decodes the ID opcode into the EX control
// register, with stall hold, flush bubbles, load-use hazard stalls of
// programmable length, an illegal-opcode flag and a saturating bubble counter.
module control_unit_pipe #(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int ALU_OP_W = 2,
   parameter int LU_STALL = 1,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               reset,
   control_unit_pipe_if.slave bus
);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6);

   // Value loaded into the stall counter when a hazard fires; the hazard
   // cycle itself is the first bubble.
   localparam logic [3:0] LU_RELOAD = 4'(LU_STALL - 1);

   typedef struct packed {
      logic                reg_dst;
      logic                branch;
      logic                branch_ne;
      logic                jump;
      logic                mem_read;
      logic                mem_to_reg;
      logic                mem_write;
      logic                alu_src;
      logic                reg_write;
      logic [ALU_OP_W-1:0] alu_op;
      logic                illegal;
   } ctrl_t;

   ctrl_t            dec_ctrl;
   ctrl_t            ctrl_q, ctrl_d;
   logic             ex_valid_q, ex_valid_d;
   logic [REG_W-1:0] ex_rt_q, ex_rt_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             bump;
   logic             uses_rt;
   logic             cnt_busy;
   logic             hazard;

   // Opcode decode into a control word; undefined opcodes set only the illegal flag
   always_comb begin
      dec_ctrl = '0;
      unique case (bus.opcode)
         OP_R: begin
            dec_ctrl.reg_dst   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = ALU_OP_W'(2'b10);
         end
         OP_LW: begin
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
         end
         OP_SW: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALU_OP_W'(2'b01);
         end
         OP_ADDI: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
         end
         OP_BNE: begin
            dec_ctrl.branch_ne = 1'b1;
            dec_ctrl.alu_op    = ALU_OP_W'(2'b01);
         end
         OP_J: begin
            dec_ctrl.jump = 1'b1;
         end
         default: begin
            dec_ctrl.illegal = 1'b1;
         end
      endcase
   end

   // Opcodes that read rt as a source operand (LW/ADDI write it instead)
   always_comb begin
      uses_rt = (bus.opcode == OP_R)   || (bus.opcode == OP_SW) ||
                (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);
   end

   assign cnt_busy = (cnt_q != 4'd0);

   // A load in EX whose destination is read by the ID instruction; $zero never stalls
   assign hazard = ex_valid_q && ctrl_q.mem_read && (ex_rt_q != '0) && bus.id_valid &&
                   ((ex_rt_q == bus.id_rs) || ((ex_rt_q == bus.id_rt) && uses_rt));

   assign bus.stall_out = ~bus.flush & (hazard | cnt_busy);

   // Next-state selection: flush > external stall > pending stall > hazard > load
   always_comb begin
      ctrl_d       = ctrl_q;
      ex_valid_d   = ex_valid_q;
      ex_rt_d      = ex_rt_q;
      cnt_d        = cnt_q;
      bump         = 1'b0;
      bubble_cnt_d = bubble_cnt_q;
      if (bus.flush) begin
         ctrl_d     = '0;
         ex_valid_d = 1'b0;
         cnt_d      = 4'd0;
         bump       = 1'b1;
      end else if (bus.stall_in) begin
         // hold everything, including the pending stall count
      end else if (cnt_busy) begin
         ctrl_d     = '0;
         ex_valid_d = 1'b0;
         cnt_d      = cnt_q - 4'd1;
         bump       = 1'b1;
      end else if (hazard) begin
         ctrl_d     = '0;
         ex_valid_d = 1'b0;
         cnt_d      = LU_RELOAD;
         bump       = 1'b1;
      end else if (bus.id_valid) begin
         ctrl_d     = dec_ctrl;
         ex_valid_d = 1'b1;
         ex_rt_d    = bus.id_rt;
      end else begin
         // empty ID slot: idle bubble, not counted as an inserted bubble
         ctrl_d     = '0;
         ex_valid_d = 1'b0;
      end
      if (bump && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   // ID/EX control register, stall counter and bubble counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q       <= '0;
         ex_valid_q   <= 1'b0;
         ex_rt_q      <= '0;
         cnt_q        <= 4'd0;
         bubble_cnt_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         ex_valid_q   <= ex_valid_d;
         ex_rt_q      <= ex_rt_d;
         cnt_q        <= cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.ex_valid   = ex_valid_q;
   assign bus.reg_dst    = ctrl_q.reg_dst;
   assign bus.branch     = ctrl_q.branch;
   assign bus.branch_ne  = ctrl_q.branch_ne;
   assign bus.jump       = ctrl_q.jump;
   assign bus.mem_read   = ctrl_q.mem_read;
   assign bus.mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.mem_write  = ctrl_q.mem_write;
   assign bus.alu_src    = ctrl_q.alu_src;
   assign bus.reg_write  = ctrl_q.reg_write;
   assign bus.alu_op     = ctrl_q.alu_op;
   assign bus.ex_rt      = ex_rt_q;
   assign bus.illegal_op = ctrl_q.illegal;
   assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe: two instances (stall length 1 with a
// 4-bit bubble counter, stall length 3 with a 16-bit counter) share one stimulus
// stream and are compared every cycle against a behavioural reference model.
module tb_control_unit_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [5:0] opcode;
   logic [4:0] id_rs, id_rt;
   logic       stall_in, flush;

   int n_checks = 0;
   int n_fail   = 0;
   int n_step   = 0;
   bit so1, so3;

   always #5 clk = ~clk;

   control_unit_pipe_if #(.OPCODE_W(6), .REG_W(5), .ALU_OP_W(2), .CNT_W(4))  bus1 ();
   control_unit_pipe_if #(.OPCODE_W(6), .REG_W(5), .ALU_OP_W(2), .CNT_W(16)) bus3 ();

   assign bus1.id_valid = id_valid;
   assign bus1.opcode   = opcode;
   assign bus1.id_rs    = id_rs;
   assign bus1.id_rt    = id_rt;
   assign bus1.stall_in = stall_in;
   assign bus1.flush    = flush;
   assign bus3.id_valid = id_valid;
   assign bus3.opcode   = opcode;
   assign bus3.id_rs    = id_rs;
   assign bus3.id_rt    = id_rt;
   assign bus3.stall_in = stall_in;
   assign bus3.flush    = flush;

   control_unit_pipe #(.OPCODE_W(6), .REG_W(5), .ALU_OP_W(2), .LU_STALL(1), .CNT_W(4))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   control_unit_pipe #(.OPCODE_W(6), .REG_W(5), .ALU_OP_W(2), .LU_STALL(3), .CNT_W(16))
      dut3 (.clk(clk), .reset(reset), .bus(bus3));

   // Packed view of every registered output of each instance
   logic [63:0] obs1, obs3;
   assign obs1 = 64'({bus1.ex_valid, bus1.reg_dst, bus1.branch, bus1.branch_ne, bus1.jump,
                      bus1.mem_read, bus1.mem_to_reg, bus1.mem_write, bus1.alu_src,
                      bus1.reg_write, bus1.alu_op, bus1.ex_rt, bus1.illegal_op, bus1.bubble_cnt});
   assign obs3 = 64'({bus3.ex_valid, bus3.reg_dst, bus3.branch, bus3.branch_ne, bus3.jump,
                      bus3.mem_read, bus3.mem_to_reg, bus3.mem_write, bus3.alu_src,
                      bus3.reg_write, bus3.alu_op, bus3.ex_rt, bus3.illegal_op, bus3.bubble_cnt});

   // ---------------- reference model ----------------
   typedef struct packed {
      bit        valid;
      bit [8:0]  ctl;    // reg_dst,branch,branch_ne,jump,mem_read,mem_to_reg,mem_write,alu_src,reg_write
      bit [1:0]  aop;
      bit [4:0]  rt;
      bit        ill;
      bit [31:0] owed;   // bubbles still owed after the one inserted on the hazard
      bit [31:0] bub;
   } mstate_t;

   mstate_t m1, m3;

   function automatic mstate_t m_reset();
      mstate_t s;
      s = '0;
      return s;
   endfunction

   // Control word for an opcode, written as the decode table rows: {ctl, alu_op, illegal}
   function automatic bit [11:0] m_decode(input logic [5:0] op);
      case (op)
         6'd0:    return {9'b1000000_01, 2'b10, 1'b0};
         6'd1:    return {9'b0000110_11, 2'b00, 1'b0};
         6'd2:    return {9'b0000001_10, 2'b00, 1'b0};
         6'd3:    return {9'b0100000_00, 2'b01, 1'b0};
         6'd4:    return {9'b0000000_11, 2'b00, 1'b0};
         6'd5:    return {9'b0010000_00, 2'b01, 1'b0};
         6'd6:    return {9'b0001000_00, 2'b00, 1'b0};
         default: return {9'b0, 2'b00, 1'b1};
      endcase
   endfunction

   function automatic bit m_hazard(input mstate_t s);
      bit reads_rt;
      reads_rt = (opcode == 6'd0) || (opcode == 6'd2) || (opcode == 6'd3) || (opcode == 6'd5);
      return s.valid && s.ctl[4] && (s.rt != 5'd0) && id_valid &&
             ((s.rt == id_rs) || ((s.rt == id_rt) && reads_rt));
   endfunction

   function automatic mstate_t m_bubble(input mstate_t s, input int cmax);
      mstate_t r;
      r = s;
      r.valid = 1'b0;
      r.ctl   = '0;
      r.aop   = '0;
      r.ill   = 1'b0;
      if (r.bub < 32'(cmax)) r.bub = r.bub + 32'd1;
      return r;
   endfunction

   // One clock edge of the pipeline register, from the priority rules
   function automatic mstate_t m_step(input mstate_t s, input int lu, input int cmax);
      mstate_t    r;
      bit  [11:0] w;
      r = s;
      if (flush) begin
         r = m_bubble(s, cmax);
         r.owed = 0;
      end else if (stall_in) begin
         r = s;
      end else if (s.owed != 0) begin
         r = m_bubble(s, cmax);
         r.owed = s.owed - 32'd1;
      end else if (m_hazard(s)) begin
         r = m_bubble(s, cmax);
         r.owed = 32'(lu - 1);
      end else if (id_valid) begin
         w       = m_decode(opcode);
         r.valid = 1'b1;
         r.ctl   = w[11:3];
         r.aop   = w[2:1];
         r.ill   = w[0];
         r.rt    = id_rt;
      end else begin
         r.valid = 1'b0;
         r.ctl   = '0;
         r.aop   = '0;
         r.ill   = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [63:0] m_pack(input mstate_t s, input int cw);
      logic [63:0] v;
      v = 64'({s.valid, s.ctl, s.aop, s.rt, s.ill});
      v = (v << cw) | 64'(s.bub);
      return v;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input bit st, input bit fl);
      id_valid = v;
      opcode   = op;
      id_rs    = rs;
      id_rt    = rt;
      stall_in = st;
      flush    = fl;
   endtask

   // One transaction: check stall_out before the edge, then the registered outputs after it
   task automatic step();
      bit e1, e3;
      @(negedge clk);
      e1  = !flush && (m_hazard(m1) || (m1.owed != 0));
      e3  = !flush && (m_hazard(m3) || (m3.owed != 0));
      so1 = bus1.stall_out;
      so3 = bus3.stall_out;
      check("d1.stall_out", 64'(so1), 64'(e1));
      check("d3.stall_out", 64'(so3), 64'(e3));
      @(posedge clk);
      #1;
      m1 = m_step(m1, 1, 15);
      m3 = m_step(m3, 3, 65535);
      check("d1.ex_reg", obs1, m_pack(m1, 4));
      check("d3.ex_reg", obs3, m_pack(m3, 16));
      n_step++;
      $display("step %0d v=%0d op=%0h rs=%0d rt=%0d st=%0d fl=%0d | d1 so=%0d out=%0h | d3 so=%0d out=%0h",
               n_step, id_valid, opcode, id_rs, id_rt, stall_in, flush, so1, obs1, so3, obs3);
   endtask

   // Asynchronous reset asserted mid-cycle, then released just after an edge
   task automatic do_reset();
      #3;
      reset = 1'b0;
      #1;
      check("d1.reset_out", obs1, 64'd0);
      check("d3.reset_out", obs3, 64'd0);
      check("d1.reset_stall", 64'(bus1.stall_out), 64'd0);
      check("d3.reset_stall", 64'(bus3.stall_out), 64'd0);
      m1 = m_reset();
      m3 = m_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      $display("reset applied and released");
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 6'd0, 5'd0, 5'd0, 0, 0);
      m1 = m_reset();
      m3 = m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("d1.por", obs1, 64'd0);
      check("d3.por", obs3, 64'd0);
      reset = 1'b1;

      // warm-up traffic so the following reset really lands mid-run
      for (int i = 0; i < 20; i++) begin
         drive($urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
         step();
      end

      // T1: reset mid-run, then ADDI
      do_reset();
      drive(1, 6'd4, 5'd1, 5'd3, 0, 0);
      step();
      check("t1.alu_src", 64'(bus1.alu_src), 64'd1);
      check("t1.reg_write", 64'(bus1.reg_write), 64'd1);
      check("t1.alu_op", 64'(bus1.alu_op), 64'd0);

      // T2: LW rt=5 then R-type rs=5, one-bubble stall
      drive(1, 6'd1, 5'd0, 5'd5, 0, 0);
      step();
      drive(1, 6'd0, 5'd5, 5'd9, 0, 0);
      step();
      check("t2.stall_on", 64'(so1), 64'd1);
      check("t2.bubble", 64'(bus1.ex_valid), 64'd0);
      step();
      check("t2.stall_off", 64'(so1), 64'd0);
      check("t2.r_in_ex", 64'({bus1.ex_valid, bus1.reg_dst, bus1.alu_op}), 64'b1_1_10);
      check("t2.bubble_cnt", 64'(bus1.bubble_cnt), 64'd1);

      // T3: LW rt=7 then SW rt=7, three-bubble stall; then rt=0 never stalls
      do_reset();
      drive(1, 6'd1, 5'd0, 5'd7, 0, 0);
      step();
      drive(1, 6'd2, 5'd1, 5'd7, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3.stall_on", 64'(so3), 64'd1);
      end
      step();
      check("t3.stall_off", 64'(so3), 64'd0);
      check("t3.sw_in_ex", 64'({bus3.ex_valid, bus3.mem_write}), 64'b11);
      check("t3.bubble_cnt", 64'(bus3.bubble_cnt), 64'd3);
      drive(1, 6'd1, 5'd0, 5'd0, 0, 0);
      step();
      drive(1, 6'd2, 5'd0, 5'd0, 0, 0);
      step();
      check("t3.rt0_d1", 64'(so1), 64'd0);
      check("t3.rt0_d3", 64'(so3), 64'd0);

      // T4: BEQ held by stall_in for four cycles
      drive(1, 6'd3, 5'd1, 5'd2, 0, 0);
      step();
      drive(1, 6'd0, 5'd3, 5'd4, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4.hold", 64'({bus1.branch, bus1.alu_op, bus3.branch, bus3.alu_op}), 64'b1_01_1_01);
      end
      // stall_in freezes a pending hazard stall
      do_reset();
      drive(1, 6'd1, 5'd0, 5'd4, 0, 0);
      step();
      drive(1, 6'd0, 5'd4, 5'd0, 0, 0);
      step();
      drive(1, 6'd0, 5'd4, 5'd0, 1, 0);
      step();
      check("t4.frozen_a", 64'(so3), 64'd1);
      step();
      check("t4.frozen_b", 64'(so3), 64'd1);
      drive(1, 6'd0, 5'd4, 5'd0, 0, 0);
      step();
      check("t4.resume_a", 64'(so3), 64'd1);
      step();
      check("t4.resume_b", 64'(so3), 64'd1);
      step();
      check("t4.resume_end", 64'(so3), 64'd0);

      // T5: flush while two bubbles are still owed
      do_reset();
      drive(1, 6'd1, 5'd0, 5'd4, 0, 0);
      step();
      drive(1, 6'd0, 5'd4, 5'd1, 0, 0);
      step();
      drive(1, 6'd0, 5'd4, 5'd1, 0, 1);
      step();
      check("t5.flush_stall", 64'(so3), 64'd0);
      check("t5.flush_bubble", 64'({bus3.ex_valid, bus3.bubble_cnt}), {47'd0, 1'b0, 16'd2});
      drive(1, 6'd0, 5'd4, 5'd1, 0, 0);
      step();
      check("t5.after_stall", 64'(so3), 64'd0);
      check("t5.after_load", 64'({bus3.ex_valid, bus3.reg_dst}), 64'b11);

      // T6: illegal opcode, then bubble counter saturation
      drive(1, 6'h3F, 5'd1, 5'd2, 0, 0);
      step();
      check("t6.illegal", 64'(bus1.illegal_op), 64'd1);
      check("t6.ctl_zero", 64'({bus1.reg_dst, bus1.branch, bus1.branch_ne, bus1.jump,
                                bus1.mem_read, bus1.mem_to_reg, bus1.mem_write,
                                bus1.alu_src, bus1.reg_write, bus1.alu_op}), 64'd0);
      drive(0, 6'd0, 5'd0, 5'd0, 0, 1);
      repeat (20) step();
      check("t6.sat_d1", 64'(bus1.bubble_cnt), 64'd15);
      check("t6.cnt_d3", 64'(bus3.bubble_cnt), 64'd22);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         if ($urandom_range(0, 99) == 0) do_reset();
         r = $urandom_range(0, 9);
         drive($urandom_range(0, 4) != 0, (r < 8) ? 6'(r) : 6'h3F,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
